// File: rtl/lfsr_share_arb_if.sv
// Handshake bundle between the LFSR share arbiter (master) and its consumers (slave).
interface lfsr_share_arb_if #(
  parameter int NREQ = 4
);
  logic [7:0]      seed;
  logic            seed_ld;
  logic [NREQ-1:0] req;
  logic [7:0]      burst_len;
  logic            rnd_rdy;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rnd_data;
  logic            rnd_vld;
  logic            busy;
  logic            done;

  modport master (
    input  seed, seed_ld, req, burst_len, rnd_rdy,
    output gnt, rnd_data, rnd_vld, busy, done
  );

  modport slave (
    output seed, seed_ld, req, burst_len, rnd_rdy,
    input  gnt, rnd_data, rnd_vld, busy, done
  );
endinterface

// File: rtl/lfsr_share_arb.sv
// Round-robin share of one x^8+x^6+x^5+x^4+1 LFSR; grant 1 cycle after REQ, RND_RDY low holds the byte.
// Optional LFSR_IDLE_SPIN_EN: the LFSR also steps every IDLE cycle that has no reseed load.
module lfsr_share_arb #(
  parameter int         NREQ      = 4,
  parameter logic [7:0] INIT_SEED = 8'hA5
) (
  input  logic               mclk,
  input  logic               mrst_n,
  lfsr_share_arb_if.master   bus
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BURST    = 1'b1;
  localparam logic [7:0] RST_SEED = (INIT_SEED == 8'h00) ? 8'h01 : INIT_SEED;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [0:0]      state;
  logic [7:0]      lfsr;
  logic [7:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] gnt;
  logic            done;
  logic            pend;
  logic [7:0]      pend_seed;

  logic            win_vld;
  logic [PW-1:0]   win;
  logic            beat;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // An all-zero state would lock the LFSR forever.
  function automatic logic [7:0] nz_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // Search upward from ptr+1; iterating from the far end lets the nearest hit win.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  assign beat = (state == BURST) && bus.rnd_rdy;

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state     <= IDLE;
      lfsr      <= RST_SEED;
      cnt       <= 8'h00;
      ptr       <= PTR_RST;
      gnt       <= '0;
      done      <= 1'b0;
      pend      <= 1'b0;
      pend_seed <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // A fresh load beats a deferred one, which beats the optional spin.
        if (bus.seed_ld) begin
          lfsr <= nz_seed(bus.seed);
        end else if (pend) begin
          lfsr <= pend_seed;
        end
`ifdef LFSR_IDLE_SPIN_EN
        else begin
          lfsr <= lfsr_step(lfsr);
        end
`endif
        pend <= 1'b0;
        if (win_vld) begin
          gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
          ptr   <= win;
          cnt   <= bus.burst_len - 8'd1;
          state <= BURST;
        end
      end else begin
        if (bus.seed_ld) begin
          pend      <= 1'b1;
          pend_seed <= nz_seed(bus.seed);
        end
        if (beat) begin
          lfsr <= lfsr_step(lfsr);
          cnt  <= cnt - 8'd1;
        end
        if (beat && (cnt == 8'h00)) begin
          state <= IDLE;
          gnt   <= '0;
          done  <= 1'b1;
        end else if (!bus.req[ptr]) begin
          state <= IDLE;
          gnt   <= '0;
        end
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rnd_data = lfsr;
  assign bus.rnd_vld  = (state == BURST);
  assign bus.busy     = (state == BURST);
  assign bus.done     = done;

endmodule

// File: tb/tb_lfsr_share_arb.sv
// Directed bench for lfsr_share_arb: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_lfsr_share_arb;

  logic mclk   = 1'b0;
  logic mrst_n = 1'b0;
  always #5 mclk = ~mclk;

  lfsr_share_arb_if #(.NREQ(4)) bus ();

  lfsr_share_arb #(.NREQ(4), .INIT_SEED(8'hA5)) dut (
    .mclk   (mclk),
    .mrst_n (mrst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [7:0] bl;
    logic       sld;
    logic [7:0] seed;
    logic [3:0] e_gnt;
    logic       e_vld;
    logic [7:0] e_data;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic [3:0] req, input logic rdy, input logic [7:0] bl,
                              input logic sld, input logic [7:0] seed, input logic [3:0] g,
                              input logic v, input logic [7:0] d, input logic dn, input logic b);
    vec_t t;
    t.req = req; t.rdy = rdy; t.bl = bl; t.sld = sld; t.seed = seed;
    t.e_gnt = g; t.e_vld = v; t.e_data = d; t.e_done = dn; t.e_busy = b;
    return t;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic drive(input logic [3:0] req, input logic rdy, input logic [7:0] bl,
                       input logic sld, input logic [7:0] seed);
    bus.req = req; bus.rnd_rdy = rdy; bus.burst_len = bl; bus.seed_ld = sld; bus.seed = seed;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt),      32'h0);
    chk({tag, "_vld"},  32'(bus.rnd_vld),  32'h0);
    chk({tag, "_busy"}, 32'(bus.busy),     32'h0);
    chk({tag, "_done"}, 32'(bus.done),     32'h0);
    chk({tag, "_data"}, 32'(bus.rnd_data), 32'hA5);
  endtask

  task automatic do_reset();
    tick();
    drive(4'h0, 1'b0, 8'd0, 1'b0, 8'h00);
    mrst_n = 1'b0;
    tick();
    chk_reset("rst");
    mrst_n = 1'b1;
  endtask

  task automatic wait_gnt();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.gnt != 4'h0) break;
    end
  endtask

  initial begin
    logic [3:0] rr_exp[5];
    logic [7:0] m;
    int beats;

    tbl[0]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h0, 0, 8'hA5, 0, 0);
    tbl[1]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'hA5, 0, 1);
    tbl[2]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'h4A, 0, 1);
    tbl[3]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'h95, 0, 1);
    tbl[4]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'h2A, 0, 1);
    tbl[5]  = mk(4'h0, 1, 8'd4, 0, 8'h00,  4'h0, 0, 8'h54, 1, 0);
    tbl[6]  = mk(4'h0, 0, 8'd4, 1, 8'hA5,  4'h0, 0, 8'h54, 0, 0);
    tbl[7]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h0, 0, 8'hA5, 0, 0);
    tbl[8]  = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'hA5, 0, 1);
    tbl[9]  = mk(4'h1, 0, 8'd4, 0, 8'h00,  4'h1, 1, 8'h4A, 0, 1);
    tbl[10] = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'h4A, 0, 1);
    tbl[11] = mk(4'h1, 0, 8'd4, 0, 8'h00,  4'h1, 1, 8'h95, 0, 1);
    tbl[12] = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'h95, 0, 1);
    tbl[13] = mk(4'h1, 0, 8'd4, 0, 8'h00,  4'h1, 1, 8'h2A, 0, 1);
    tbl[14] = mk(4'h1, 1, 8'd4, 0, 8'h00,  4'h1, 1, 8'h2A, 0, 1);
    tbl[15] = mk(4'h0, 1, 8'd4, 0, 8'h00,  4'h0, 0, 8'h54, 1, 0);
    tbl[16] = mk(4'h1, 1, 8'd2, 1, 8'h00,  4'h0, 0, 8'h54, 0, 0);
    tbl[17] = mk(4'h1, 1, 8'd2, 0, 8'h00,  4'h1, 1, 8'h01, 0, 1);
    tbl[18] = mk(4'h1, 1, 8'd2, 0, 8'h00,  4'h1, 1, 8'h02, 0, 1);
    tbl[19] = mk(4'h0, 1, 8'd2, 0, 8'h00,  4'h0, 0, 8'h04, 1, 0);
    tbl[20] = mk(4'h0, 0, 8'd2, 0, 8'h00,  4'h0, 0, 8'h04, 0, 0);

    drive(4'h0, 1'b0, 8'd0, 1'b0, 8'h00);
    tick();
    chk_reset("por");
    tick();
    mrst_n = 1'b1;

    // Per cycle: check the state left by the previous edge, then drive this cycle's inputs.
    for (int i = 0; i < 21; i++) begin
      tick();
      chk($sformatf("v%0d_gnt", i),  32'(bus.gnt),      32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_vld", i),  32'(bus.rnd_vld),  32'(tbl[i].e_vld));
      chk($sformatf("v%0d_data", i), 32'(bus.rnd_data), 32'(tbl[i].e_data));
      chk($sformatf("v%0d_done", i), 32'(bus.done),     32'(tbl[i].e_done));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy),     32'(tbl[i].e_busy));
      drive(tbl[i].req, tbl[i].rdy, tbl[i].bl, tbl[i].sld, tbl[i].seed);
    end

    // Round robin from reset, one IDLE cycle between single-beat bursts.
    do_reset();
    rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4; rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;
    drive(4'hF, 1'b1, 8'd1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      chk($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(rr_exp[k]));
      tick();
      chk($sformatf("rr%0d_gap", k), 32'(bus.gnt), 32'h0);
    end

    // Reseed during a burst is deferred; last captured value wins.
    do_reset();
    drive(4'h1, 1'b1, 8'd4, 1'b0, 8'h00);
    tick();
    chk("sd_b0", 32'(bus.rnd_data), 32'hA5);
    drive(4'h1, 1'b1, 8'd4, 1'b1, 8'h11);
    tick();
    chk("sd_b1", 32'(bus.rnd_data), 32'h4A);
    drive(4'h1, 1'b1, 8'd4, 1'b1, 8'h3C);
    tick();
    chk("sd_b2", 32'(bus.rnd_data), 32'h95);
    drive(4'h1, 1'b1, 8'd4, 1'b0, 8'h00);
    tick();
    chk("sd_b3", 32'(bus.rnd_data), 32'h2A);
    tick();
    chk("sd_done", 32'(bus.done), 32'h1);
    chk("sd_idle", 32'(bus.gnt), 32'h0);
    tick();
    chk("sd_gnt2", 32'(bus.gnt), 32'h1);
    chk("sd_new0", 32'(bus.rnd_data), 32'h3C);
    tick();
    chk("sd_new1", 32'(bus.rnd_data), 32'(step(8'h3C)));
    drive(4'h1, 1'b1, 8'd4, 1'b1, 8'h77);
    tick();
    // Reset mid-burst drops the pending reseed.
    drive(4'h0, 1'b0, 8'd4, 1'b0, 8'h00);
    mrst_n = 1'b0;
    #1;
    chk_reset("mid");
    tick();
    mrst_n = 1'b1;
    tick();
    tick();
    chk("pend_lost", 32'(bus.rnd_data), 32'hA5);

    // BURST_LEN=0 means 256 beats.
    drive(4'h1, 1'b1, 8'd0, 1'b0, 8'h00);
    wait_gnt();
    beats = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.done) break;
      if (bus.rnd_vld && bus.rnd_rdy) beats++;
      tick();
    end
    drive(4'h0, 1'b1, 8'd0, 1'b0, 8'h00);
    chk("b256_done", 32'(bus.done), 32'h1);
    chk("b256_beats", 32'(beats), 32'd256);
    m = 8'hA5;
    for (int k = 0; k < 256; k++) m = step(m);
    chk("b256_data", 32'(bus.rnd_data), 32'(m));

    // Abort after three accepted beats: back to IDLE, no DONE.
    drive(4'h1, 1'b1, 8'd10, 1'b0, 8'h00);
    wait_gnt();
    chk("ab_gnt", 32'(bus.gnt), 32'h1);
    tick();
    tick();
    tick();
    drive(4'h0, 1'b0, 8'd10, 1'b0, 8'h00);
    tick();
    for (int k = 0; k < 3; k++) m = step(m);
    chk("ab_gnt0", 32'(bus.gnt), 32'h0);
    chk("ab_vld",  32'(bus.rnd_vld), 32'h0);
    chk("ab_busy", 32'(bus.busy), 32'h0);
    chk("ab_done", 32'(bus.done), 32'h0);
    chk("ab_data", 32'(bus.rnd_data), 32'(m));
    tick();
    chk("ab_done2", 32'(bus.done), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
